// File: rtl/or1200_tb_exit_monitor.sv
// Snoops completed data-bus writes for the console and exit test registers,
// buffers console bytes in a FIFO and produces the done/pass run verdict.
module or1200_tb_exit_monitor #(
    parameter logic [31:0] CONSOLE_ADDR   = 32'h8000_0000,
    parameter logic [31:0] EXIT_ADDR      = 32'h8000_0004,
    parameter int unsigned FIFO_DEPTH     = 16,
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd1_000_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        dwb_cyc,
    input  logic        dwb_stb,
    input  logic        dwb_we,
    input  logic        dwb_ack,
    input  logic [31:0] dwb_adr,
    input  logic [31:0] dwb_dat_o,
    input  logic [3:0]  dwb_sel,
    output logic        chr_valid,
    output logic [7:0]  chr_data,
    input  logic        chr_ready,
    output logic        fifo_overflow,
    output logic        done,
    output logic        pass,
    output logic        timeout,
    output logic [31:0] exit_code,
    output logic [31:0] cycle_count
);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_DONE} state_t;

    state_t           state, state_next;
    logic [7:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] rd_ptr, wr_ptr, rd_ptr_next;
    logic [PTR_W:0]   count, count_next;
    logic             hit, console_wr, exit_wr, fifo_full;
    logic             pop, push, drop, wd_hit, timeout_set;
    logic [7:0]       console_byte, head_next;
    logic             unused_adr;

    assign unused_adr = ^dwb_adr[1:0];

    assign hit        = dwb_cyc & dwb_stb & dwb_we & dwb_ack;
    assign console_wr = hit && (dwb_adr[31:2] == CONSOLE_ADDR[31:2]) && (dwb_sel != 4'b0000);
    assign exit_wr    = hit && (dwb_adr[31:2] == EXIT_ADDR[31:2]);
    assign fifo_full  = (count == DEPTH_CNT);
    assign pop        = chr_valid & chr_ready;
    assign push       = console_wr && (state == ST_RUN) && (!fifo_full || pop);
    assign drop       = console_wr && (state == ST_RUN) && fifo_full && !pop;
    assign wd_hit     = (TIMEOUT_CYCLES != 32'd0) && (cycle_count == TIMEOUT_CYCLES - 32'd1)
                        && (state != ST_DONE);

    // Big-endian l.sb: the byte lives in the lane of the highest set select bit.
    always_comb begin
        console_byte = dwb_dat_o[7:0];
        if (dwb_sel == 4'b1111) console_byte = dwb_dat_o[7:0];
        else if (dwb_sel[3])    console_byte = dwb_dat_o[31:24];
        else if (dwb_sel[2])    console_byte = dwb_dat_o[23:16];
        else if (dwb_sel[1])    console_byte = dwb_dat_o[15:8];
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        rd_ptr_next = pop ? rd_ptr + PTR_W'(1) : rd_ptr;
        count_next  = count;
        if (push && !pop)      count_next = count + (PTR_W + 1)'(1);
        else if (pop && !push) count_next = count - (PTR_W + 1)'(1);
        head_next = 8'h00;
        if (count_next != '0)
            head_next = (push && rd_ptr_next == wr_ptr) ? console_byte : mem[rd_ptr_next];
    end

    always_comb begin
        state_next  = state;
        timeout_set = 1'b0;
        case (state)
            ST_RUN: begin
                if (exit_wr) begin
                    state_next = ST_DRAIN;
                end else if (wd_hit) begin
                    state_next  = ST_DONE;
                    timeout_set = 1'b1;
                end
            end
            ST_DRAIN: begin
                if (count == '0) begin
                    state_next = ST_DONE;
                end else if (wd_hit) begin
                    state_next  = ST_DONE;
                    timeout_set = 1'b1;
                end
            end
            ST_DONE:  state_next = ST_DONE;
            default:  state_next = ST_RUN;
        endcase
    end

    // NOTE: the byte storage carries no reset; emptiness is tracked by count and chr_valid.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= console_byte;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= ST_RUN;
            rd_ptr        <= '0;
            wr_ptr        <= '0;
            count         <= '0;
            chr_valid     <= 1'b0;
            chr_data      <= 8'h00;
            fifo_overflow <= 1'b0;
            done          <= 1'b0;
            pass          <= 1'b0;
            timeout       <= 1'b0;
            exit_code     <= 32'd0;
            cycle_count   <= 32'd0;
        end else begin
            state     <= state_next;
            rd_ptr    <= rd_ptr_next;
            count     <= count_next;
            chr_valid <= (count_next != '0);
            chr_data  <= head_next;
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (drop) fifo_overflow <= 1'b1;
            if (state == ST_RUN && exit_wr) exit_code <= dwb_dat_o;
            if (state != ST_DONE) cycle_count <= cycle_count + 32'd1;
            if (timeout_set) timeout <= 1'b1;
            done <= (state_next == ST_DONE);
            // Overflow and exit code are frozen once the run leaves RUN.
            pass <= (state_next == ST_DONE) && !(timeout || timeout_set)
                    && !fifo_overflow && (exit_code == 32'd0);
        end
    end
endmodule

// File: tb/tb_or1200_tb_exit_monitor.sv
// Self-checking bench: directed scenarios plus randomized bus traffic, all
// compared against a queue-based model of the console/exit monitor.
module tb_or1200_tb_exit_monitor;
    localparam logic [31:0] CON   = 32'h8000_0000;
    localparam logic [31:0] EXI   = 32'h8000_0004;
    localparam int unsigned DEPTH = 16;
    localparam logic [31:0] TO    = 32'd100;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        dwb_cyc, dwb_stb, dwb_we, dwb_ack;
    logic [31:0] dwb_adr, dwb_dat_o;
    logic [3:0]  dwb_sel;
    logic        chr_valid, chr_ready;
    logic [7:0]  chr_data;
    logic        fifo_overflow, done, pass, timeout;
    logic [31:0] exit_code, cycle_count;

    int n_checks = 0;
    int n_pass   = 0;

    or1200_tb_exit_monitor #(
        .CONSOLE_ADDR(CON), .EXIT_ADDR(EXI), .FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .dwb_cyc(dwb_cyc), .dwb_stb(dwb_stb), .dwb_we(dwb_we), .dwb_ack(dwb_ack),
        .dwb_adr(dwb_adr), .dwb_dat_o(dwb_dat_o), .dwb_sel(dwb_sel),
        .chr_valid(chr_valid), .chr_data(chr_data), .chr_ready(chr_ready),
        .fifo_overflow(fifo_overflow), .done(done), .pass(pass), .timeout(timeout),
        .exit_code(exit_code), .cycle_count(cycle_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Reference model: a byte queue plus run flags, advanced at every clock edge.
    byte unsigned mq[$];
    logic        m_exited, m_done, m_timeout, m_ovf, m_pass;
    logic [31:0] m_code, m_cycles;
    bit          started = 0;

    always @(posedge clk) begin
        if (!rst_n) begin
            mq.delete();
            m_exited = 0; m_done = 0; m_timeout = 0; m_ovf = 0; m_pass = 0;
            m_code = 0; m_cycles = 0;
            started = 1;
        end else begin
            bit is_hit, is_con, is_exit, can_pop, wd, running, drained, accept;
            byte unsigned b;
            is_hit  = dwb_cyc && dwb_stb && dwb_we && dwb_ack;
            is_con  = is_hit && (dwb_adr[31:2] == CON[31:2]) && (dwb_sel != 4'b0000);
            is_exit = is_hit && (dwb_adr[31:2] == EXI[31:2]);
            can_pop = (mq.size() > 0) && chr_ready;
            wd      = !m_done && (m_cycles == TO - 1);
            running = !m_exited && !m_done;
            drained = m_exited && !m_done && (mq.size() == 0);
            accept  = (mq.size() < DEPTH) || can_pop;
            b = dwb_dat_o[7:0];
            if (dwb_sel != 4'hF)
                for (int k = 0; k < 4; k++) if (dwb_sel[k]) b = dwb_dat_o[8*k +: 8];
            if (can_pop) void'(mq.pop_front());
            if (running && is_con) begin
                if (accept) mq.push_back(b);
                else m_ovf = 1;
            end
            if (!m_done) m_cycles = m_cycles + 1;
            if (running && is_exit) begin
                m_exited = 1;
                m_code = dwb_dat_o;
            end else if (drained) begin
                m_done = 1;
            end else if (wd) begin
                m_done = 1;
                m_timeout = 1;
            end
            m_pass = m_done && !m_timeout && !m_ovf && (m_code == 0);
        end
    end

    always @(negedge clk) begin
        if (started) begin
            check("m_chr_valid", 32'(chr_valid), 32'(mq.size() != 0));
            check("m_chr_data", 32'(chr_data), (mq.size() != 0) ? 32'(mq[0]) : 32'd0);
            check("m_overflow", 32'(fifo_overflow), 32'(m_ovf));
            check("m_done", 32'(done), 32'(m_done));
            check("m_pass", 32'(pass), 32'(m_pass));
            check("m_timeout", 32'(timeout), 32'(m_timeout));
            check("m_exit_code", exit_code, m_code);
            check("m_cycle_count", cycle_count, m_cycles);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish, got running expected finished");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        dwb_cyc = 0; dwb_stb = 0; dwb_we = 0; dwb_ack = 0;
        dwb_adr = 0; dwb_dat_o = 0; dwb_sel = 0;
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        dwb_cyc = 1; dwb_stb = 1; dwb_we = 1; dwb_ack = 1;
        dwb_adr = a; dwb_dat_o = d; dwb_sel = s;
        step();
        idle();
    endtask

    task automatic do_reset();
        rst_n = 0;
        chr_ready = 0;
        idle();
        step();
        rst_n = 1;
    endtask

    task automatic drain_and_collect(input int max_cycles, output int popped, output bit ok_order,
                                     input byte unsigned exp_bytes[$]);
        popped = 0;
        ok_order = 1;
        chr_ready = 1;
        for (int i = 0; i < max_cycles && !done; i++) begin
            if (chr_valid) begin
                if (popped >= exp_bytes.size() || chr_data != exp_bytes[popped]) ok_order = 0;
                popped++;
            end
            step();
        end
        chr_ready = 0;
    endtask

    initial begin
        byte unsigned exp_q[$];
        int popped;
        bit ok_order;
        chr_ready = 0;
        idle();
        do_reset();

        // Reset state.
        check("rst_valid", 32'(chr_valid), 0);
        check("rst_done", 32'(done), 0);
        check("rst_cycles", cycle_count, 0);

        // Hello path, with ignored sel=0 and read cycles first.
        do_reset();
        bus_write(CON, 32'h0000_0055, 4'b0000);
        dwb_cyc = 1; dwb_stb = 1; dwb_we = 0; dwb_ack = 1; dwb_adr = CON; dwb_sel = 4'hF;
        step();
        idle();
        check("ignored_writes", 32'(chr_valid), 0);
        chr_ready = 1;
        bus_write(CON, 32'h4800_0000, 4'b1000);
        check("hello_valid0", 32'(chr_valid), 1);
        check("hello_byte0", 32'(chr_data), 32'h48);
        bus_write(CON, 32'h0069_0000, 4'b0100);
        check("hello_byte1", 32'(chr_data), 32'h69);
        step();
        check("hello_empty", 32'(chr_valid), 0);
        chr_ready = 0;

        // Clean exit at cycle 10.
        do_reset();
        repeat (10) step();
        bus_write(EXI, 32'h0, 4'hF);
        check("clean_not_done", 32'(done), 0);
        step();
        check("clean_done", 32'(done), 1);
        check("clean_pass", 32'(pass), 1);
        check("clean_code", exit_code, 0);
        check("clean_cycles", cycle_count, 12);
        repeat (3) step();
        check("clean_frozen", cycle_count, 12);

        // Drain ordering.
        do_reset();
        bus_write(CON, 32'hDEAD_BE41, 4'hF);
        bus_write(CON, 32'h0000_4200, 4'b0010);
        bus_write(CON, 32'h0000_0043, 4'b0001);
        bus_write(EXI, 32'd5, 4'b0001);
        check("drain_head", 32'(chr_data), 32'h41);
        chr_ready = 1;
        repeat (3) step();
        check("drain_held", 32'(done), 0);
        step();
        check("drain_done", 32'(done), 1);
        check("drain_pass", 32'(pass), 0);
        check("drain_code", exit_code, 5);
        chr_ready = 0;

        // Overflow: one more byte than fits.
        do_reset();
        for (int i = 0; i <= DEPTH; i++) bus_write(CON, 32'(i), 4'hF);
        check("ovf_flag", 32'(fifo_overflow), 1);
        bus_write(EXI, 32'h0, 4'hF);
        exp_q.delete();
        for (int i = 0; i < DEPTH; i++) exp_q.push_back(byte'(i));
        drain_and_collect(40, popped, ok_order, exp_q);
        check("ovf_retained", 32'(popped), DEPTH);
        check("ovf_order", 32'(ok_order), 1);
        check("ovf_done", 32'(done), 1);
        check("ovf_pass", 32'(pass), 0);

        // Full FIFO plus simultaneous push and pop.
        do_reset();
        for (int i = 0; i < DEPTH; i++) bus_write(CON, 32'h10 + 32'(i), 4'hF);
        check("full_no_ovf", 32'(fifo_overflow), 0);
        check("full_head", 32'(chr_data), 32'h10);
        chr_ready = 1;
        bus_write(CON, 32'hAA, 4'hF);
        chr_ready = 0;
        check("simul_no_ovf", 32'(fifo_overflow), 0);
        check("simul_head", 32'(chr_data), 32'h11);
        bus_write(EXI, 32'h0, 4'hF);
        exp_q.delete();
        for (int i = 1; i < DEPTH; i++) exp_q.push_back(byte'(8'h10 + i));
        exp_q.push_back(8'hAA);
        drain_and_collect(40, popped, ok_order, exp_q);
        check("simul_count", 32'(popped), DEPTH);
        check("simul_order", 32'(ok_order), 1);
        check("simul_pass", 32'(pass), 1);

        // Watchdog.
        do_reset();
        repeat (99) step();
        check("wd_before", 32'(done), 0);
        check("wd_cnt99", cycle_count, 99);
        step();
        check("wd_done", 32'(done), 1);
        check("wd_timeout", 32'(timeout), 1);
        check("wd_pass", 32'(pass), 0);
        check("wd_cycles", cycle_count, 100);
        repeat (3) step();
        check("wd_frozen", cycle_count, 100);

        // Reset in the middle of DRAIN.
        do_reset();
        bus_write(CON, 32'h5A, 4'hF);
        bus_write(EXI, 32'd7, 4'hF);
        rst_n = 0;
        step();
        check("mid_rst_valid", 32'(chr_valid), 0);
        check("mid_rst_data", 32'(chr_data), 0);
        check("mid_rst_ovf", 32'(fifo_overflow), 0);
        check("mid_rst_done", 32'(done), 0);
        check("mid_rst_pass", 32'(pass), 0);
        check("mid_rst_timeout", 32'(timeout), 0);
        check("mid_rst_code", exit_code, 0);
        check("mid_rst_cycles", cycle_count, 0);
        rst_n = 1;
        bus_write(CON, 32'h33, 4'hF);
        check("post_rst_run", 32'(chr_valid), 1);
        check("post_rst_byte", 32'(chr_data), 32'h33);
        check("post_rst_cycles", cycle_count, 1);

        // Randomized traffic against the model.
        for (int r = 0; r < 25; r++) begin
            do_reset();
            for (int c = 0; c < 130; c++) begin
                int sel_kind;
                sel_kind = $urandom_range(0, 19);
                dwb_cyc = ($urandom_range(0, 7) != 0);
                dwb_stb = ($urandom_range(0, 7) != 0);
                dwb_we  = ($urandom_range(0, 7) != 0);
                dwb_ack = ($urandom_range(0, 7) != 0);
                if (sel_kind < 12)       dwb_adr = CON | 32'($urandom_range(0, 3));
                else if (sel_kind == 19) dwb_adr = EXI | 32'($urandom_range(0, 3));
                else                     dwb_adr = $urandom & 32'hFFFF_FFF8;
                dwb_dat_o = ($urandom_range(0, 1) != 0) ? $urandom : 32'(8'($urandom));
                if (sel_kind == 19 && $urandom_range(0, 1) != 0) dwb_dat_o = 0;
                dwb_sel   = 4'($urandom);
                chr_ready = ($urandom_range(0, 2) == 0);
                step();
            end
            idle();
            chr_ready = 0;
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
